// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen -- RV32I immediate generator (KLP32 decode stage)
//
// Decodes instruction bits [31:7] into the 32-bit immediate for the I, S, B,
// U and J formats selected by imm_sel. The result is registered so it lines
// up with the decode->execute pipeline register (one-cycle latency).
//
// Build option:
//   IMMGEN_ZIMM_EN  when defined, imm_sel=101 selects the CSR zimm immediate
//                   (zero-extended rs1 field). When undefined, 101 is illegal.
//
// Ports:
//   clk           in   1   clock, rising edge
//   rst           in   1   synchronous active-high reset (priority over in_valid)
//   instr         in   25  instruction bits [31:7]
//   imm_sel       in   k   000=I 001=S 010=B 011=U 100=J (101=zimm option)
//   in_valid      in   1   instr/imm_sel valid this cycle
//   imm_extended  out  n   registered immediate
//   out_valid     out  1   imm_extended is a fresh result this cycle
//   sel_err       out  1   last accepted imm_sel was illegal
// -----------------------------------------------------------------------------
module imm_gen #(
   parameter int k = 3,
   parameter int n = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:7]   instr,
   input  logic [k-1:0]  imm_sel,
   input  logic          in_valid,
   output logic [n-1:0]  imm_extended,
   output logic          out_valid,
   output logic          sel_err
);

   localparam logic [k-1:0] SEL_I    = 3'b000;
   localparam logic [k-1:0] SEL_S    = 3'b001;
   localparam logic [k-1:0] SEL_B    = 3'b010;
   localparam logic [k-1:0] SEL_U    = 3'b011;
   localparam logic [k-1:0] SEL_J    = 3'b100;
   localparam logic [k-1:0] SEL_ZIMM = 3'b101;

   // Pure combinational decode. Bit n is the illegal-select flag; an illegal
   // select yields a zero immediate.
   function automatic logic [n:0] f_decode(input logic [31:7]  i,
                                           input logic [k-1:0] sel);
      logic [n:0] r;
      r = '0;
      case (sel)
         SEL_I: r = {1'b0, {20{i[31]}}, i[31:20]};
         SEL_S: r = {1'b0, {20{i[31]}}, i[31:25], i[11:7]};
         SEL_B: r = {1'b0, {19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         SEL_U: r = {1'b0, i[31:12], 12'b0};
         SEL_J: r = {1'b0, {11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
`ifdef IMMGEN_ZIMM_EN
         SEL_ZIMM: r = {1'b0, 27'b0, i[19:15]};
`else
         SEL_ZIMM: r = {1'b1, {n{1'b0}}};
`endif
         default: r = {1'b1, {n{1'b0}}};
      endcase
      return r;
   endfunction

   logic [n:0]   w_dec_p0;
   logic [n-1:0] r_imm_p1;
   logic         r_err_p1;
   logic         r_vld_p1;

   always_comb begin
      w_dec_p0 = f_decode(instr, imm_sel);
   end

   // ---- stage p0 -> p1 register ----
   // Immediate and error flag only load on an accepted beat; they hold
   // otherwise while the valid drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_imm_p1 <= '0;
         r_err_p1 <= 1'b0;
         r_vld_p1 <= 1'b0;
      end else if (in_valid) begin
         r_imm_p1 <= w_dec_p0[n-1:0];
         r_err_p1 <= w_dec_p0[n];
         r_vld_p1 <= 1'b1;
      end else begin
         r_vld_p1 <= 1'b0;
      end
   end

   assign imm_extended = r_imm_p1;
   assign sel_err      = r_err_p1;
   assign out_valid    = r_vld_p1;

endmodule

// File: tb/tb_imm_gen.sv
// -----------------------------------------------------------------------------
// tb_imm_gen -- self-checking bench for imm_gen.
// Directed format/control steps followed by randomized beats, all checked
// against an arithmetic reference model of the RV32I immediate rules.
// -----------------------------------------------------------------------------
module tb_imm_gen;

   logic        clk;
   logic        rst;
   logic [31:7] instr;
   logic [2:0]  imm_sel;
   logic        in_valid;
   logic [31:0] imm_extended;
   logic        out_valid;
   logic        sel_err;

   int vectors;
   int miscompares;

   // model state
   logic [31:0] e_imm;
   logic        e_err;
   logic        e_vld;

   imm_gen #(.k(3), .n(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr        (instr),
      .imm_sel      (imm_sel),
      .in_valid     (in_valid),
      .imm_extended (imm_extended),
      .out_valid    (out_valid),
      .sel_err      (sel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: immediates computed as signed integer values from the fields.
   function automatic void ref_imm(input logic [31:7] ins, input logic [2:0] sel,
                                   output logic [31:0] imm, output logic err);
      logic [31:0] w;
      int s;
      int v;
      w   = {ins, 7'b0};
      s   = $signed(w);
      v   = 0;
      err = 1'b0;
      case (sel)
         3'd0: v = s >>> 20;
         3'd1: v = ((s >>> 25) * 32) + int'(w[11:7]);
         3'd2: v = (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0)
                   + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
         3'd3: v = $signed(w & 32'hFFFFF000);
         3'd4: v = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096
                   + (w[20] ? 2048 : 0) + int'(w[30:21]) * 2;
`ifdef IMMGEN_ZIMM_EN
         3'd5: v = int'(w[19:15]);
`else
         3'd5: err = 1'b1;
`endif
         default: err = 1'b1;
      endcase
      imm = v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply one beat, clock it, update the model, compare all outputs.
   task automatic step(input logic r, input logic v, input logic [31:7] ins,
                       input logic [2:0] sel);
      logic [31:0] m_imm;
      logic        m_err;
      rst      = r;
      in_valid = v;
      instr    = ins;
      imm_sel  = sel;
      @(posedge clk);
      #1;
      if (r) begin
         e_imm = '0; e_err = 1'b0; e_vld = 1'b0;
      end else if (v) begin
         ref_imm(ins, sel, m_imm, m_err);
         e_imm = m_imm; e_err = m_err; e_vld = 1'b1;
      end else begin
         e_vld = 1'b0;
      end
      check("imm", imm_extended, e_imm);
      check("sel_err", {31'b0, sel_err}, {31'b0, e_err});
      check("out_valid", {31'b0, out_valid}, {31'b0, e_vld});
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      e_imm = '0; e_err = 1'b0; e_vld = 1'b0;
      rst = 1'b1; in_valid = 1'b0; instr = '0; imm_sel = '0;

      // reset state
      step(1'b1, 1'b0, 25'h0, 3'b000);
      check("rst_imm", imm_extended, 32'h0);

      // format examples with hand-derived results
      step(1'b0, 1'b1, 25'b0000000001001000000000010, 3'b000);
      check("I_const", imm_extended, 32'h00000004);
      step(1'b0, 1'b1, 25'b0000000000000001001000001, 3'b001);
      check("S_const", imm_extended, 32'h00000001);
      step(1'b0, 1'b1, 25'b1111111000000000010001100, 3'b010);
      check("B_const", imm_extended, 32'hFFFFF7EC);
      step(1'b0, 1'b1, 25'b0001001001100101000000001, 3'b011);
      check("U_const", imm_extended, 32'h12650000);
      step(1'b0, 1'b1, 25'b1111111111110000000010001, 3'b100);
      check("J_const", imm_extended, 32'hFFF00FFE);

      // U with sign bit set stays within bit 31
      step(1'b0, 1'b1, 25'h1FFFFFF, 3'b011);
      check("U_top", imm_extended, 32'hFFFFF000);

      // in_valid=0 holds imm, drops valid
      step(1'b0, 1'b0, 25'h0AAAAAA, 3'b000);
      check("hold_imm", imm_extended, 32'hFFFFF000);

      // illegal selects
      step(1'b0, 1'b1, 25'h1FFFFFF, 3'b110);
      check("sel110_err", {31'b0, sel_err}, 32'd1);
      step(1'b0, 1'b0, 25'h0, 3'b000);
      check("err_hold", {31'b0, sel_err}, 32'd1);
      step(1'b0, 1'b1, 25'h1FFFFFF, 3'b111);
      step(1'b0, 1'b1, 25'h0, 3'b000);
      check("err_clear", {31'b0, sel_err}, 32'd0);

      // zimm select with rs1 field all ones
      step(1'b0, 1'b1, {5'b0, 7'b0, 5'h1F, 8'b0}, 3'b101);
`ifdef IMMGEN_ZIMM_EN
      check("zimm", imm_extended, 32'h0000001F);
`else
      check("zimm_illegal", {31'b0, sel_err}, 32'd1);
`endif

      // reset wins over in_valid
      step(1'b0, 1'b1, 25'h1FFFFFF, 3'b110);
      step(1'b1, 1'b1, 25'h1FFFFFF, 3'b100);
      check("rst_pri", imm_extended, 32'h0);

      // randomized beats
      for (int t = 0; t < 400; t++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
              25'($urandom), 3'($urandom_range(0, 7)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
